// File: rtl/legv8_mem_pkg.sv
// Shared widths, FSM state type and response record for the LEGv8 load/store path.
// Defining LEGV8_STORE_READBACK_EN adds the VERIFY state used for store readback.
package legv8_mem_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_OFF_W    = 9;
    localparam int DEF_READ_LAT = 1;

`ifdef LEGV8_STORE_READBACK_EN
    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        VERIFY
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;
`endif

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  error;
    } resp_t;

endpackage

// File: rtl/legv8_dt_addr_gen.sv
// Combinational LEGv8 D-format address: zero-extended base plus sign-extended DT offset,
// with an out-of-range flag instead of wrap-around.
module legv8_dt_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int OFF_W  = 9
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [OFF_W-1:0]  offset,
    output logic [ADDR_W-1:0] addr,
    output logic              out_of_range
);

    // Two guard bits keep the full-precision sum and its sign.
    localparam int SUM_W = ((ADDR_W > OFF_W) ? ADDR_W : OFF_W) + 2;

    logic signed [SUM_W-1:0] base_ext;
    logic signed [SUM_W-1:0] off_ext;
    logic signed [SUM_W-1:0] sum;

    assign base_ext     = $signed({{(SUM_W-ADDR_W){1'b0}}, base});
    assign off_ext      = $signed({{(SUM_W-OFF_W){offset[OFF_W-1]}}, offset});
    assign sum          = base_ext + off_ext;
    assign out_of_range = sum[SUM_W-1] | (|sum[SUM_W-2:ADDR_W]);
    assign addr         = sum[ADDR_W-1:0];

endmodule

// File: rtl/legv8_mem_access_unit.sv
// LDUR/STUR initiator between execute and the single-port data memory; all outputs registered.
// Optional LEGV8_STORE_READBACK_EN re-reads every stored word and flags a mismatch.
module legv8_mem_access_unit
    import legv8_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OFF_W    = DEF_OFF_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_base,
    input  logic [OFF_W-1:0]  req_offset,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic              mem_read_flag,
    output logic              mem_write_flag,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_LAT - 1);

    state_t            state;
    logic              is_store;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] calc_addr;
    logic              calc_oor;

    legv8_dt_addr_gen #(
        .ADDR_W (ADDR_W),
        .OFF_W  (OFF_W)
    ) u_addr_gen (
        .base         (req_base),
        .offset       (req_offset),
        .addr         (calc_addr),
        .out_of_range (calc_oor)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_read_flag  <= 1'b0;
            mem_write_flag <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= '0;
            is_store       <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        is_store   <= req_write;
                        wait_cnt   <= '0;
                        if (calc_oor) begin
                            // Bad address: answer immediately, memory untouched.
                            resp_error <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_error     <= 1'b0;
                            mem_address    <= calc_addr;
                            mem_wdata      <= req_wdata;
                            mem_read_flag  <= ~req_write;
                            mem_write_flag <= req_write;
                            state          <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    mem_write_flag <= 1'b0;
                    if (is_store) begin
`ifdef LEGV8_STORE_READBACK_EN
                        mem_read_flag <= 1'b1;
                        state         <= VERIFY;
`else
                        mem_read_flag <= 1'b0;
                        resp_valid    <= 1'b1;
                        state         <= RESP;
`endif
                    end else begin
                        mem_read_flag <= 1'b0;
                        state         <= WAIT;
                    end
                end

`ifdef LEGV8_STORE_READBACK_EN
                VERIFY: begin
                    mem_read_flag <= 1'b0;
                    state         <= WAIT;
                end
`endif

                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        resp_rdata <= mem_rdata;
`ifdef LEGV8_STORE_READBACK_EN
                        resp_error <= is_store && (mem_rdata != mem_wdata);
`endif
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state          <= IDLE;
                    req_ready      <= 1'b1;
                    resp_valid     <= 1'b0;
                    mem_read_flag  <= 1'b0;
                    mem_write_flag <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_mem_access_unit.sv
// Randomized and directed bench for legv8_mem_access_unit against a word-array reference model.
// Build with LEGV8_STORE_READBACK_EN defined to exercise the store readback path.
module tb_legv8_mem_access_unit;
    import legv8_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_base;
    logic [8:0]  req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read_flag;
    logic        mem_write_flag;
    logic [7:0]  mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    bit          preload;
    bit          corrupt_wr;

    int ncyc = 0, rd_tot = 0, wr_tot = 0, rd_last = 0, wr_last = 0, both_tot = 0, ovl_tot = 0;

    legv8_mem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_base       (req_base),
        .req_offset     (req_offset),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_read_flag  (mem_read_flag),
        .mem_write_flag (mem_write_flag),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port data memory, one-cycle registered read; bit 0 can be corrupted on write.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= i;
            mem_rdata <= '0;
        end else begin
            if (mem_write_flag) mem[mem_address] <= corrupt_wr ? (mem_wdata ^ 32'h1) : mem_wdata;
            if (mem_read_flag)  mem_rdata <= mem[mem_address];
        end
    end

    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (mem_read_flag)  begin rd_tot = rd_tot + 1; rd_last = ncyc; end
        if (mem_write_flag) begin wr_tot = wr_tot + 1; wr_last = ncyc; end
        if (mem_read_flag && mem_write_flag) both_tot = both_tot + 1;
        if (req_ready && resp_valid) ovl_tot = ovl_tot + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full transaction; entered and left at a falling edge.
    task automatic do_txn(input bit wr, input int base, input int off, input logic [31:0] wd,
                          input int hold, input bit corrupt);
        int    addr, lat, exp_lat, exp_rd, exp_wr, c0, rd0, wr0, both0, ovl0;
        bit    oor;
        resp_t exp;
        addr = base + off;
        oor  = (addr < 0) || (addr > 255);
        if (oor) begin
            exp_lat = 1; exp.rdata = '0; exp.error = 1'b1; exp_rd = 0; exp_wr = 0;
        end else if (!wr) begin
            exp_lat = 3; exp.rdata = ref_mem[addr]; exp.error = 1'b0; exp_rd = 1; exp_wr = 0;
        end else begin
            ref_mem[addr] = corrupt ? (wd ^ 32'h1) : wd;
`ifdef LEGV8_STORE_READBACK_EN
            exp_lat = 4; exp.rdata = ref_mem[addr]; exp.error = corrupt; exp_rd = 1; exp_wr = 1;
`else
            exp_lat = 2; exp.rdata = '0; exp.error = 1'b0; exp_rd = 0; exp_wr = 1;
`endif
        end
        corrupt_wr = corrupt;
        check_eq("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_base   = base[7:0];
        req_offset = off[8:0];
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        c0 = ncyc; rd0 = rd_tot; wr0 = wr_tot; both0 = both_tot; ovl0 = ovl_tot;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        #1;
        check_eq("resp_latency", lat, exp_lat);
        check_eq("resp_rdata", resp_rdata, exp.rdata);
        check_eq("resp_error", resp_error, exp.error);
        check_eq("req_ready_busy", req_ready, 0);
        if (!oor) check_eq("mem_address_held", mem_address, addr);
        check_eq("read_pulses", rd_tot - rd0, exp_rd);
        check_eq("write_pulses", wr_tot - wr0, exp_wr);
        if (exp_wr == 1) check_eq("write_cycle", wr_last - c0, 1);
        if (exp_rd == 1) check_eq("read_cycle", rd_last - c0, wr ? 2 : 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", resp_valid, 1);
            check_eq("hold_rdata", resp_rdata, exp.rdata);
            check_eq("hold_error", resp_error, exp.error);
            check_eq("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check_eq("done_valid", resp_valid, 0);
        check_eq("done_req_ready", req_ready, 1);
        check_eq("total_read_pulses", rd_tot - rd0, exp_rd);
        check_eq("total_write_pulses", wr_tot - wr0, exp_wr);
        check_eq("flags_exclusive", both_tot - both0, 0);
        check_eq("ready_valid_overlap", ovl_tot - ovl0, 0);
        corrupt_wr = 1'b0;
    endtask

    initial begin
        int rd0;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        rst_n = 1'b0; preload = 1'b1; corrupt_wr = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_base = '0; req_offset = '0; req_wdata = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = i;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_rdata", resp_rdata, 0);
        check_eq("rst_resp_error", resp_error, 0);
        check_eq("rst_read_flag", mem_read_flag, 0);
        check_eq("rst_write_flag", mem_write_flag, 0);
        check_eq("rst_mem_address", mem_address, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1; preload = 1'b0;
        @(negedge clk);

        do_txn(0, 10, 5, 32'h0, 0, 0);
        do_txn(1, 200, -8, 32'hDEADBEEF, 0, 0);
        do_txn(0, 192, 0, 32'h0, 0, 0);
        do_txn(0, 250, 10, 32'h0, 0, 0);
        do_txn(1, 3, -4, 32'hCAFEF00D, 0, 0);
        do_txn(0, 0, 0, 32'h0, 0, 0);
        do_txn(0, 255, 0, 32'h0, 0, 0);
        do_txn(0, 0, -1, 32'h0, 0, 0);
        do_txn(0, 255, 1, 32'h0, 0, 0);
        do_txn(0, 7, 0, 32'h0, 5, 0);

        // Reset asserted for one edge while a load sits in WAIT.
        check_eq("rstmid_ready", req_ready, 1);
        rd0 = rd_tot;
        req_valid = 1'b1; req_write = 1'b0; req_base = 8'd5; req_offset = 9'd2; req_wdata = '0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_access_read", mem_read_flag, 1);
        @(negedge clk);
        check_eq("rstmid_wait_read", mem_read_flag, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rstmid_read_flag", mem_read_flag, 0);
        check_eq("rstmid_write_flag", mem_write_flag, 0);
        check_eq("rstmid_req_ready", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            check_eq("rstmid_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        check_eq("rstmid_read_pulses", rd_tot - rd0, 1);

`ifdef LEGV8_STORE_READBACK_EN
        do_txn(1, 40, 0, 32'h12345678, 0, 1);
        do_txn(0, 40, 0, 32'h0, 0, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            int b, o;
            b = $urandom_range(0, 255);
            o = $urandom_range(0, 511) - 256;
            if ($urandom_range(0, 3) != 0) o = $urandom_range(0, 255) - b;
            do_txn($urandom_range(0, 1), b, o, $urandom, $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/legv8_mem_access_unit.md
Name: legv8_mem_access_unit

Overview:
- Load/store initiator for the LEGv8 datapath. It sits between the execute stage and the single-port data memory and drives that memory's read/write flags, address and write data.
- Accepts one LDUR/STUR request at a time over a valid/ready handshake and computes the word address as base + signed DT offset.
- Sequences the memory's one-cycle registered read and returns load data or a store acknowledgement over a valid/ready response channel.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, word-address width; memory depth is 2^ADDR_W.
- OFF_W, 9, signed DT offset width.
- READ_LAT, 1, cycles from the edge that samples mem_read_flag to mem_rdata being valid.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store (STUR), 0 = load (LDUR)
- req_base  in  ADDR_W  unsigned base word address
- req_offset  in  OFF_W  two's-complement word offset
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  load data (0 for stores)
- resp_error  out  1  address out of range, or readback mismatch
- mem_read_flag  out  1  to data memory read flag
- mem_write_flag  out  1  to data memory write flag
- mem_address  out  ADDR_W  to data memory address
- mem_wdata  out  DATA_W  to data memory write data
- mem_rdata  in  DATA_W  from data memory registered read output

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: every output is registered and resets to 0, except req_ready, which is 1 in IDLE. State resets to IDLE.
- Reset mid-operation: the access is abandoned, flags drop at that edge, and no response is issued.
- Handshake: a request is accepted on an edge where req_valid && req_ready. req_ready is 1 only in IDLE, so there is exactly one outstanding access. A response completes on an edge where resp_valid && resp_ready. resp_valid and the response fields hold stable until that edge.
- Address: the full-precision sum is base (zero-extended) + offset (sign-extended). A sum < 0 or > 2^ADDR_W-1 is out of range. There is no wrap-around.
- States:
  - IDLE: on accept with an in-range address, register address and data and go to ACCESS. On accept with an out-of-range address, go to RESP with resp_error=1; the memory is never touched.
  - ACCESS: exactly one of mem_read_flag/mem_write_flag is high, for exactly one cycle. Loads go to WAIT; stores go to RESP.
  - WAIT: counts READ_LAT cycles, then captures mem_rdata into resp_rdata and goes to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE.
- Latency, counted from the accept edge (edge 0):
  - Load: resp_valid in cycle 3.
  - Store: resp_valid in cycle 2.
  - Error: resp_valid in cycle 1.
- Back-to-back: the next request is accepted in the first IDLE cycle after the response completes. req_ready is never high in the same cycle as resp_valid.
- mem_address and mem_wdata are held from ACCESS through RESP. Flags are 0 in every other state and are never both high.

Optional Feature:
- Macro: LEGV8_STORE_READBACK_EN.
- With the macro defined:
  - After a store's ACCESS, the unit issues a verify read of the same address (an extra ACCESS-read cycle), then WAIT.
  - resp_rdata is the readback value; resp_error=1 if it differs from the stored data.
  - Store latency becomes 4 cycles.
- Without the macro: stores respond in cycle 2 with resp_rdata=0 and resp_error=0.

Decomposition:
- Package legv8_mem_pkg holds:
  - DATA_W, ADDR_W, OFF_W defaults;
  - state enum {IDLE, ACCESS, WAIT, RESP}, plus VERIFY under the macro;
  - the response struct (rdata, error).
- One sub-module is natural: legv8_dt_addr_gen, a combinational base+offset adder that outputs the address and an out-of-range flag. It is reusable by the future prefetch/forwarding logic.

Test Plan:
- Data memory model is preloaded with mem[i]=i. Load base=10, offset=+5 -> one read-flag pulse at address 15; resp_valid in cycle 3 with rdata=15, error=0.
- Store base=200, offset=-8, wdata=0xDEADBEEF -> one write-flag pulse at address 192; resp_valid in cycle 2; a following load of 192 returns 0xDEADBEEF.
- Out of range:
  - base=250, offset=+10 -> resp_error=1 in cycle 1, no flag asserted;
  - base=3, offset=-4 -> same.
  - Boundaries base=0, offset=0 and base=255, offset=0 are accepted.
- Backpressure: hold resp_ready=0 for 5 cycles on a load of address 7 -> resp fields stable (rdata=7), req_ready=0 throughout; completion on the first edge with resp_ready=1.
- Assert rst_n=0 for one edge during WAIT of a load -> flags 0, resp_valid never rises, unit in IDLE with req_ready=1 the next cycle.
- LEGV8_STORE_READBACK_EN: store 0x12345678 to address 40 with the memory model forced to corrupt bit 0 -> read pulse follows the write pulse, resp_error=1, rdata=0x12345679.
